// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters; gnt to rvalid is 2 cycles.
// One operation in flight; a result waits in RESP until its owner asserts rready, holding off further grants.
module alu_arbiter #(
  parameter int DW  = 8,
  parameter int OPW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [DW-1:0]  a0,
  input  logic [DW-1:0]  b0,
  input  logic [OPW-1:0] op0,
  output logic           gnt0,
  output logic           rvalid0,
  output logic [DW-1:0]  rdata0,
  output logic           rcarry0,
  input  logic           rready0,
  input  logic           req1,
  input  logic [DW-1:0]  a1,
  input  logic [DW-1:0]  b1,
  input  logic [OPW-1:0] op1,
  output logic           gnt1,
  output logic           rvalid1,
  output logic [DW-1:0]  rdata1,
  output logic           rcarry1,
  input  logic           rready1,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_dout,
  input  logic           alu_carry,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   last;
  logic   sel;
  logic   sel_vld;
  logic   rready_own;

  // On contention the requester not served last wins; a lone requester always wins.
  always_comb begin
    sel_vld    = req0 | req1;
    sel        = (req0 & req1) ? ~last : req1;
    rready_own = owner ? rready1 : rready0;
    state_nxt  = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld && !rst) begin
          gnt0      = ~sel;
          gnt1      = sel;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rready_own) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= 1'b0;
      last    <= 1'b1;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      rdata0  <= '0;
      rcarry0 <= 1'b0;
      rvalid0 <= 1'b0;
      rdata1  <= '0;
      rcarry1 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            alu_a  <= sel ? a1 : a0;
            alu_b  <= sel ? b1 : b0;
            alu_op <= sel ? op1 : op0;
            owner  <= sel;
          end
        end
        EXEC: begin
          if (owner) begin
            rdata1  <= alu_dout;
            rcarry1 <= alu_carry;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= alu_dout;
            rcarry0 <= alu_carry;
            rvalid0 <= 1'b1;
          end
        end
        RESP: begin
          if (rready_own) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            last    <= owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
